// File: rtl/sub_share_pkg.sv
// Shared types and helpers for the Sub-unit sharing arbiter.
package sub_share_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StResp
  } state_e;

  // Wide enough for the largest legal Sub latency (7).
  localparam int unsigned CNT_W = 3;

  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub_share_rr.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module sub_share_rr
  import sub_share_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned ID_W = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx
);

  logic [N_REQ-1:0] w_rot;
  logic [ID_W-1:0]  w_off;
  logic [ID_W:0]    w_sum;

  // Rotate so bit 0 is the requester at the pointer.
  assign w_rot = N_REQ'({i_req, i_req} >> i_ptr);

  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = ID_W'(k);
    end
  end

  always_comb begin
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= (ID_W + 1)'(N_REQ)) w_sum = w_sum - (ID_W + 1)'(N_REQ);
  end

  assign o_idx   = w_sum[ID_W-1:0];
  assign o_grant = (|i_req) ? (N_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/sub_share_arb.sv
// Arbitrates N_REQ one-bit requesters onto a single external Sub unit,
// one transaction in flight, round-robin fairness.
module sub_share_arb
  import sub_share_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned SUB_LAT = 1,
  localparam int unsigned ID_W   = id_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ-1:0] req_data,
  output logic [N_REQ-1:0] req_ready,
  output logic             sub_i,
  input  logic             sub_o,
  output logic             rsp_valid,
  output logic [ID_W-1:0]  rsp_id,
  output logic             rsp_data,
  input  logic             rsp_ready
);

  state_e            r_state, w_state_d;
  logic [ID_W-1:0]   r_ptr, w_ptr_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_bit, w_bit_d;
  logic              r_rsp_data, w_rsp_data_d;
  logic [ID_W-1:0]   r_rsp_id, w_rsp_id_d;

  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_idx;

  sub_share_rr #(
    .N_REQ(N_REQ)
  ) u_rr (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_bit      <= 1'b0;
      r_rsp_data <= 1'b0;
      r_rsp_id   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_ptr      <= w_ptr_d;
      r_cnt      <= w_cnt_d;
      r_bit      <= w_bit_d;
      r_rsp_data <= w_rsp_data_d;
      r_rsp_id   <= w_rsp_id_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_ptr_d      = r_ptr;
    w_cnt_d      = r_cnt;
    w_bit_d      = r_bit;
    w_rsp_data_d = r_rsp_data;
    w_rsp_id_d   = r_rsp_id;
    req_ready    = '0;
    sub_i        = 1'b0;
    rsp_valid    = 1'b0;
    unique case (r_state)
      StIdle: begin
        // The grant always targets a valid requester, so any request is a handshake.
        req_ready = w_grant;
        if (|req_valid) begin
          w_bit_d    = req_data[w_idx];
          w_rsp_id_d = w_idx;
          w_cnt_d    = CNT_W'(SUB_LAT);
          w_state_d  = StDrive;
        end
      end
      StDrive: begin
        sub_i = r_bit;
        if (r_cnt == '0) begin
          w_rsp_data_d = sub_o;
          w_state_d    = StResp;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StResp: begin
        sub_i     = r_bit;
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_ptr_d   = (r_rsp_id == ID_W'(N_REQ - 1)) ? '0 : r_rsp_id + 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign rsp_id   = r_rsp_id;
  assign rsp_data = r_rsp_data;

endmodule

// File: tb/tb_sub_share_arb.sv
// Scoreboard bench for sub_share_arb with an inverting Sub model of configurable latency.
module tb_sub_share_arb;

  typedef struct {
    int   id;
    logic bit_in;
    logic data;
    int   cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [3:0] req_data = '0;
  logic [3:0] req_ready;
  logic       sub_i, sub_o;
  logic       rsp_valid, rsp_data;
  logic [1:0] rsp_id;
  logic       rsp_ready = 1'b1;

  logic [3:0] rv_x = '0;
  logic [3:0] rd_x = '0;
  logic [3:0] req_ready_0, req_ready_7;
  logic       sub_i_0, sub_o_0, sub_i_7, sub_o_7;
  logic       rsp_valid_0, rsp_valid_7, rsp_data_0, rsp_data_7;
  logic [1:0] rsp_id_0, rsp_id_7;
  logic [6:0] pipe_7 = '0;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   m_ptr = 0;
  bit   m_busy = 0;
  bit   m_first = 0;
  exp_t sb[$];
  int   grant_log[$];
  int   acc_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sub unit models: inverter delayed by SUB_LAT cycles.
  always @(posedge clk) sub_o <= ~sub_i;
  assign sub_o_0 = ~sub_i_0;
  always @(posedge clk) pipe_7 <= {pipe_7[5:0], ~sub_i_7};
  assign sub_o_7 = pipe_7[6];

  sub_share_arb #(.N_REQ(4), .SUB_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .sub_i(sub_i), .sub_o(sub_o), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  sub_share_arb #(.N_REQ(4), .SUB_LAT(0)) u_dut_lat0 (
    .clk(clk), .rst(rst), .req_valid(rv_x), .req_data(rd_x), .req_ready(req_ready_0),
    .sub_i(sub_i_0), .sub_o(sub_o_0), .rsp_valid(rsp_valid_0), .rsp_id(rsp_id_0),
    .rsp_data(rsp_data_0), .rsp_ready(1'b1)
  );

  sub_share_arb #(.N_REQ(4), .SUB_LAT(7)) u_dut_lat7 (
    .clk(clk), .rst(rst), .req_valid(rv_x), .req_data(rd_x), .req_ready(req_ready_7),
    .sub_i(sub_i_7), .sub_o(sub_o_7), .rsp_valid(rsp_valid_7), .rsp_id(rsp_id_7),
    .rsp_data(rsp_data_7), .rsp_ready(1'b1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor and round-robin reference model for the SUB_LAT=1 instance.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_ptr   = 0;
      m_busy  = 0;
      m_first = 0;
    end else if (!m_busy) begin
      logic [3:0] exp_g;
      int         win;
      exp_g = '0;
      win   = 0;
      for (int k = 0; k < 4; k++) begin
        if (exp_g == 4'b0 && req_valid[(m_ptr + k) % 4]) begin
          win   = (m_ptr + k) % 4;
          exp_g = 4'b1 << win;
        end
      end
      check_eq("req_ready", {28'b0, req_ready}, {28'b0, exp_g});
      check_eq("sub_i_idle", {31'b0, sub_i}, 32'd0);
      check_eq("rsp_valid_idle", {31'b0, rsp_valid}, 32'd0);
      if (exp_g != 4'b0) begin
        exp_t e;
        e.id     = win;
        e.bit_in = req_data[win];
        e.data   = ~req_data[win];
        e.cyc    = cyc;
        sb.push_back(e);
        grant_log.push_back(win);
        acc_cyc.push_back(cyc);
        m_busy  = 1;
        m_first = 1;
      end
    end else begin
      check_eq("req_ready_busy", {28'b0, req_ready}, 32'd0);
      if (rsp_valid) begin
        if (m_first) begin
          check_eq("latency", cyc - sb[0].cyc, 32'd3);
          m_first = 0;
        end
        check_eq("rsp_id", {30'b0, rsp_id}, sb[0].id);
        check_eq("rsp_data", {31'b0, rsp_data}, {31'b0, sb[0].data});
        check_eq("sub_i_resp", {31'b0, sub_i}, {31'b0, sb[0].bit_in});
        if (rsp_ready) begin
          m_ptr  = (sb[0].id + 1) % 4;
          m_busy = 0;
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int c0, lat0, lat7, d0, d7;

    // Reset state
    tick(10);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", {28'b0, req_ready}, 32'd0);
    check_eq("rst_sub_i", {31'b0, sub_i}, 32'd0);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Single request from requester 0
    tick(1);
    req_valid = 4'b0001;
    req_data  = 4'b0001;
    tick(1);
    req_valid = '0;
    tick(8);
    check_eq("single_count", grant_log.size(), 32'd1);

    // All four continuously requesting, starting from ptr 0
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    grant_log.delete();
    acc_cyc.delete();
    req_valid = 4'b1111;
    req_data  = 4'b1010;
    tick(17);
    req_valid = '0;
    tick(8);
    check_eq("rr_count", grant_log.size(), 32'd5);
    if (grant_log.size() == 5) begin
      for (int i = 0; i < 5; i++) check_eq("rr_order", grant_log[i], i % 4);
      for (int i = 1; i < 5; i++) check_eq("rr_interval", acc_cyc[i] - acc_cyc[i-1], 32'd4);
    end

    // Backpressure on requester 2's response
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    req_data  = 4'b0100;
    tick(1);
    req_valid = 4'b1111;
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    check_eq("bp_rsp_seen", {31'b0, rsp_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check_eq("bp_id", {30'b0, rsp_id}, 32'd2);
      check_eq("bp_data", {31'b0, rsp_data}, 32'd0);
      check_eq("bp_ready", {28'b0, req_ready}, 32'd0);
    end
    tick(1);
    rsp_ready = 1'b1;
    req_valid = '0;
    tick(3);

    // Wrap: ptr is now 3
    grant_log.delete();
    req_valid = 4'b1001;
    req_data  = 4'b1001;
    tick(5);
    req_valid = '0;
    tick(6);
    check_eq("wrap_count", grant_log.size(), 32'd2);
    if (grant_log.size() == 2) begin
      check_eq("wrap_first", grant_log[0], 32'd3);
      check_eq("wrap_second", grant_log[1], 32'd0);
    end

    // Reset pulsed in DRIVE abandons the transaction and rewinds ptr
    req_valid = 4'b0010;
    req_data  = 4'b0010;
    tick(1);
    req_valid = '0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstd_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rstd_sub_i", {31'b0, sub_i}, 32'd0);
    check_eq("rstd_req_ready", {28'b0, req_ready}, 32'd0);
    tick(1);
    req_valid = 4'b1111;
    req_data  = 4'b0000;
    @(negedge clk);
    check_eq("rstd_next_grant", {28'b0, req_ready}, 32'd1);
    tick(1);
    req_valid = '0;
    tick(8);

    // Latency for SUB_LAT = 0 and 7
    rv_x = 4'b0001;
    rd_x = 4'b0001;
    c0   = cyc;
    tick(1);
    rv_x = '0;
    lat0 = -1;
    lat7 = -1;
    d0   = -1;
    d7   = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rsp_valid_0 && lat0 < 0) begin
        lat0 = cyc - c0;
        d0   = int'(rsp_data_0);
      end
      if (rsp_valid_7 && lat7 < 0) begin
        lat7 = cyc - c0;
        d7   = int'(rsp_data_7);
      end
    end
    check_eq("lat0_latency", lat0, 32'd2);
    check_eq("lat7_latency", lat7, 32'd9);
    check_eq("lat0_data", d0, 32'd0);
    check_eq("lat7_data", d7, 32'd0);

    tick(2);
    check_eq("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sub_share_arb.md
SUB_SHARE_ARB -- requirements
Module: sub_share_arb

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing one Sub unit (legal range 1..16).
REQ-002 Parameter SUB_LAT, default 1, SHALL set the cycles from a sub_i change to a valid sub_o (legal range 0..7).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-005 Port req_valid, input, N_REQ, SHALL flag a pending one-bit request per requester.
REQ-006 Port req_data, input, N_REQ, SHALL carry each requester's input bit.
REQ-007 Port req_ready, output, N_REQ, SHALL be the one-hot acceptance to the winning requester.
REQ-008 Port sub_i, output, 1, SHALL drive the shared Sub unit's input i.
REQ-009 Port sub_o, input, 1, SHALL receive the shared Sub unit's output o.
REQ-010 Port rsp_valid, output, 1, SHALL flag a response available.
REQ-011 Port rsp_id, output, ID_W = max(1, clog2(N_REQ)), SHALL give the requester index of the response.
REQ-012 Port rsp_data, output, 1, SHALL carry the sampled sub_o.
REQ-013 Port rsp_ready, input, 1, SHALL be the consumer's acceptance of the response.

Function
REQ-014 FSM states SHALL be IDLE, DRIVE and RESP; a single transaction is in flight at a time.
REQ-015 In IDLE with any req_valid set, the block SHALL assert req_ready for exactly one winner in the same cycle, chosen round-robin starting at pointer ptr.
REQ-016 On a handshake (req_valid & req_ready), the block SHALL register req_data[winner] and the winner index, load cnt = SUB_LAT, and enter DRIVE.
REQ-017 In IDLE with no req_valid set, req_ready SHALL be all-zero and the state SHALL be held.
REQ-018 req_ready SHALL be zero in DRIVE and RESP.
REQ-019 In DRIVE, sub_i SHALL equal the registered bit; cnt SHALL decrement each cycle; when cnt==0, sub_o SHALL be registered into rsp_data and the FSM SHALL enter RESP.
REQ-020 sub_i SHALL be 0 in IDLE and SHALL hold the registered bit in RESP.
REQ-021 In RESP, rsp_valid SHALL be 1, and rsp_id and rsp_data SHALL remain stable until rsp_valid & rsp_ready.
REQ-022 On the RESP handshake, ptr SHALL become (rsp_id+1) mod N_REQ, wrapping N_REQ-1 to 0, and the FSM SHALL return to IDLE.
REQ-023 Latency from request accept to rsp_valid SHALL be SUB_LAT+2 cycles; the minimum issue interval SHALL be SUB_LAT+3 cycles.
REQ-024 A requester dropping req_valid in IDLE before a grant SHALL lose no state; the arbiter SHALL re-evaluate each cycle.
REQ-025 With N_REQ=1, the block SHALL always grant requester 0, and rsp_id SHALL be 0.

Reset
REQ-026 While rst is high at a clk edge: state SHALL go to IDLE, ptr to 0, and cnt, rsp_data, rsp_id and the registered bit to 0.
REQ-027 Outputs after reset SHALL be req_ready=0, sub_i=0 and rsp_valid=0.
REQ-028 Reset during DRIVE or RESP SHALL abandon the transaction with no response emitted.

Structure
REQ-029 Package sub_share_pkg SHALL hold the FSM state enum and the ID_W width function.
REQ-030 The round-robin picker (sub_share_rr: req vector and ptr in, one-hot grant and index out, combinational) SHALL be the one sub-module.
REQ-031 The Sub unit SHALL stay external, connected by the parent through sub_i/sub_o.

Verification
REQ-032 The bench SHALL model Sub as an inverter with SUB_LAT delay, using SUB_LAT=1 and N_REQ=4 unless stated.
REQ-033 Single request: req_valid=0001, req_data=0001 -> rsp_valid 3 cycles after accept, rsp_id=0, rsp_data=0.
REQ-034 All four requesting continuously, rsp_ready=1 -> grant order 0,1,2,3,0, one issue every 4 cycles.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_data stay stable; req_ready stays 0000.
REQ-036 Wrap: with ptr=3, req_valid=1001 -> requester 3 is granted, then requester 0.
REQ-037 rst pulsed in DRIVE -> next cycle IDLE, rsp_valid=0, sub_i=0, and the next grant goes to requester 0.
REQ-038 SUB_LAT=0 and SUB_LAT=7 -> accept-to-rsp_valid latency of 2 and 9 cycles respectively.
